// File: rtl/vga_dither_output_pkg.sv
// Shared VGA output definitions (vga_defs): channel widths, sync idle level,
// the 4x4 Bayer threshold table and small colour arithmetic helpers.
package vga_dither_output_pkg;

   localparam int IN_BITS  = 8;                      // source colour width per channel
   localparam int OUT_BITS = 3;                      // DAC width per channel
   localparam int DROP     = IN_BITS - OUT_BITS;     // LSBs removed by quantisation
   localparam int OFF_BITS = 5;                      // dither offset width (0..30)

   localparam logic SYNC_IDLE_LEVEL = 1'b1;          // VGA syncs are active-low

   // Ordered-dither thresholds, row-major, index = {row, col}
   localparam logic [3:0] BAYER4 [0:15] = '{
      4'd0,  4'd8,  4'd2,  4'd10,
      4'd12, 4'd4,  4'd14, 4'd6,
      4'd3,  4'd11, 4'd1,  4'd9,
      4'd15, 4'd7,  4'd13, 4'd5
   };

   // Stage-1 pipeline contents: saturated colour plus the qualifiers it travels with
   typedef struct packed {
      logic [IN_BITS-1:0] r;
      logic [IN_BITS-1:0] g;
      logic [IN_BITS-1:0] b;
      logic               vis;
      logic               hs;
      logic               vs;
   } stage1_t;

   // Raw 4-bit threshold for a position inside the 4x4 tile
   function automatic logic [3:0] bayer4_lookup(input logic [1:0] row, input logic [1:0] col);
      return BAYER4[{row, col}];
   endfunction

   // Add the dither offset and clamp at full scale so bright colours never wrap to dark
   function automatic logic [IN_BITS-1:0] sat_add(input logic [IN_BITS-1:0] c,
                                                  input logic [OFF_BITS-1:0] off);
      logic [IN_BITS:0] sum;
      sum = {1'b0, c} + {{(IN_BITS - OFF_BITS + 1){1'b0}}, off};
      if (sum[IN_BITS]) begin
         return {IN_BITS{1'b1}};
      end else begin
         return sum[IN_BITS-1:0];
      end
   endfunction

endpackage

// File: rtl/vga_dither_output_bayer4_threshold.sv
// Combinational 4x4 Bayer threshold lookup, scaled by 2 so the 4-bit
// threshold spans the five colour LSBs dropped on the way to the DAC.
module vga_dither_output_bayer4_threshold
   import vga_dither_output_pkg::*;
(
   input  logic [1:0]          i_col,
   input  logic [1:0]          i_row,
   output logic [OFF_BITS-1:0] o_offset
);

   // Table lookup, then shift left by one to reach the 0..30 offset range
   always_comb begin
      o_offset = {OFF_BITS{1'b0}};
      o_offset = {bayer4_lookup(i_row, i_col), 1'b0};
   end

endmodule

// File: rtl/vga_dither_output.sv
// VGA pin output stage: 4x4 ordered dithering from 8-bit to 3-bit colour,
// optional per-frame pattern rotation, blanking, and sync delay so colour
// and syncs leave the block aligned two clocks after they arrive.
module vga_dither_output
   import vga_dither_output_pkg::*;
#(
   parameter bit   TEMPORAL  = 1'b1,
   parameter logic SYNC_IDLE = SYNC_IDLE_LEVEL
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [9:0] i_hpos,
   input  logic [9:0] i_vpos,
   input  logic       i_visible,
   input  logic       i_hsync,
   input  logic       i_vsync,
   input  logic [7:0] i_r,
   input  logic [7:0] i_g,
   input  logic [7:0] i_b,
   output logic       o_vga_hsync,
   output logic       o_vga_vsync,
   output logic [2:0] o_vga_r,
   output logic [2:0] o_vga_g,
   output logic [2:0] o_vga_b,
   output logic [1:0] o_frame
);

   logic [1:0]          row_s;
   logic [OFF_BITS-1:0] offset_s;

   stage1_t             st1_d, st1_q;

   logic [2:0]          out_r_d, out_r_q;
   logic [2:0]          out_g_d, out_g_q;
   logic [2:0]          out_b_d, out_b_q;
   logic                hs2_d, hs2_q;
   logic                vs2_d, vs2_q;

   logic [1:0]          frame_d, frame_q;
   logic                vsync_prev_d, vsync_prev_q;
   logic                armed_d, armed_q;

   logic                unused_s;

   // Column and row bits above the tile size and the dropped colour LSBs are not needed
   assign unused_s = ^{i_hpos[9:2], i_vpos[9:2],
                       st1_q.r[DROP-1:0], st1_q.g[DROP-1:0], st1_q.b[DROP-1:0]};

   // Tile row: shifted by the frame phase when temporal rotation is enabled
   always_comb begin
      row_s = 2'd0;
      if (TEMPORAL) begin
         row_s = i_vpos[1:0] + frame_q;
      end else begin
         row_s = i_vpos[1:0];
      end
   end

   // One threshold per pixel, shared by all three channels
   vga_dither_output_bayer4_threshold u_threshold (
      .i_col    (i_hpos[1:0]),
      .i_row    (row_s),
      .o_offset (offset_s)
   );

   // Stage 1: dither-and-saturate each channel, capture qualifiers alongside
   always_comb begin
      st1_d     = st1_q;
      st1_d.r   = sat_add(i_r, offset_s);
      st1_d.g   = sat_add(i_g, offset_s);
      st1_d.b   = sat_add(i_b, offset_s);
      st1_d.vis = i_visible;
      st1_d.hs  = i_hsync;
      st1_d.vs  = i_vsync;
   end

   // Stage 2: quantise to the DAC width and blank outside active video
   always_comb begin
      out_r_d = 3'b000;
      out_g_d = 3'b000;
      out_b_d = 3'b000;
      if (st1_q.vis) begin
         out_r_d = st1_q.r[IN_BITS-1:DROP];
         out_g_d = st1_q.g[IN_BITS-1:DROP];
         out_b_d = st1_q.b[IN_BITS-1:DROP];
      end else begin
         out_r_d = 3'b000;
         out_g_d = 3'b000;
         out_b_d = 3'b000;
      end
      hs2_d = st1_q.hs;
      vs2_d = st1_q.vs;
   end

   // Frame phase: count vsync rising edges; the first cycle after reset only
   // primes the edge detector so a vsync already high at release is not counted
   always_comb begin
      frame_d      = frame_q;
      vsync_prev_d = i_vsync;
      armed_d      = 1'b1;
      if (armed_q && i_vsync && !vsync_prev_q) begin
         frame_d = frame_q + 2'd1;
      end else begin
         frame_d = frame_q;
      end
   end

   // Pipeline and frame-counter registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st1_q        <= '{r: 8'd0, g: 8'd0, b: 8'd0, vis: 1'b0, hs: SYNC_IDLE, vs: SYNC_IDLE};
         out_r_q      <= 3'b000;
         out_g_q      <= 3'b000;
         out_b_q      <= 3'b000;
         hs2_q        <= SYNC_IDLE;
         vs2_q        <= SYNC_IDLE;
         frame_q      <= 2'd0;
         vsync_prev_q <= 1'b0;
         armed_q      <= 1'b0;
      end else begin
         st1_q        <= st1_d;
         out_r_q      <= out_r_d;
         out_g_q      <= out_g_d;
         out_b_q      <= out_b_d;
         hs2_q        <= hs2_d;
         vs2_q        <= vs2_d;
         frame_q      <= frame_d;
         vsync_prev_q <= vsync_prev_d;
         armed_q      <= armed_d;
      end
   end

   assign o_vga_r     = out_r_q;
   assign o_vga_g     = out_g_q;
   assign o_vga_b     = out_b_q;
   assign o_vga_hsync = hs2_q;
   assign o_vga_vsync = vs2_q;
   assign o_frame     = frame_q;

endmodule

// File: tb/tb_vga_dither_output.sv
// Scoreboard bench for vga_dither_output: a temporal and a static instance
// share the same stimulus; expected pixels are queued at drive time and
// compared two clocks later.
module tb_vga_dither_output;

   logic       clk = 1'b0;
   logic       rst;
   logic [9:0] hpos, vpos;
   logic       vis, hs, vs;
   logic [7:0] r, g, b;

   logic       hs_t, vs_t, hs_s, vs_s;
   logic [2:0] r_t, g_t, b_t, r_s, g_s, b_s;
   logic [1:0] fr_t, fr_s;

   always #5 clk = ~clk;

   vga_dither_output #(.TEMPORAL(1'b1), .SYNC_IDLE(1'b1)) dut_t (
      .i_clk(clk), .i_rst(rst), .i_hpos(hpos), .i_vpos(vpos), .i_visible(vis),
      .i_hsync(hs), .i_vsync(vs), .i_r(r), .i_g(g), .i_b(b),
      .o_vga_hsync(hs_t), .o_vga_vsync(vs_t),
      .o_vga_r(r_t), .o_vga_g(g_t), .o_vga_b(b_t), .o_frame(fr_t)
   );

   vga_dither_output #(.TEMPORAL(1'b0), .SYNC_IDLE(1'b1)) dut_s (
      .i_clk(clk), .i_rst(rst), .i_hpos(hpos), .i_vpos(vpos), .i_visible(vis),
      .i_hsync(hs), .i_vsync(vs), .i_r(r), .i_g(g), .i_b(b),
      .o_vga_hsync(hs_s), .o_vga_vsync(vs_s),
      .o_vga_r(r_s), .o_vga_g(g_s), .o_vga_b(b_s), .o_frame(fr_s)
   );

   typedef struct {
      int rt, gt, bt, rs, gs, bs;
      bit hs, vs, chk;
      int kind, idx;
   } exp_t;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   int   bt_tab[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
   int   frame_m;
   bit   prev_m, armed_m;
   int   dens[16];
   int   rot[5];
   int   rotfr[5];
   int   rot_exp[5]   = '{0, 1, 0, 1, 0};
   int   rotfr_exp[5] = '{0, 1, 2, 3, 0};

   task automatic check_eq(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int model_chan(int c, int h, int v, int fr, bit vi);
      int row, off, s;
      row = ((v % 4) + fr) % 4;
      off = bt_tab[row * 4 + (h % 4)] * 2;
      s   = c + off;
      if (s > 255) s = 255;
      return vi ? (s / 32) : 0;
   endfunction

   task automatic model_reset();
      sb.delete();
      frame_m = 0;
      prev_m  = 1'b0;
      armed_m = 1'b0;
   endtask

   // Drive one pixel (called at posedge+1), queue its expectation, compare the one due now
   task automatic step(input int h, input int v, input bit vi, input bit hsi, input bit vsi,
                       input int ri, input int gi, input int bi,
                       input bit chk, input int kind, input int idx);
      exp_t e;
      hpos = h[9:0]; vpos = v[9:0]; vis = vi; hs = hsi; vs = vsi;
      r = ri[7:0]; g = gi[7:0]; b = bi[7:0];
      e.rt = model_chan(ri, h, v, frame_m, vi);
      e.gt = model_chan(gi, h, v, frame_m, vi);
      e.bt = model_chan(bi, h, v, frame_m, vi);
      e.rs = model_chan(ri, h, v, 0, vi);
      e.gs = model_chan(gi, h, v, 0, vi);
      e.bs = model_chan(bi, h, v, 0, vi);
      e.hs = hsi; e.vs = vsi; e.chk = chk; e.kind = kind; e.idx = idx;
      sb.push_back(e);
      if (armed_m && vsi && !prev_m) frame_m = (frame_m + 1) % 4;
      prev_m  = vsi;
      armed_m = 1'b1;
      @(posedge clk);
      #1;
      check_eq("frame_t", int'(fr_t), frame_m);
      check_eq("frame_s", int'(fr_s), frame_m);
      if (sb.size() == 2) begin
         e = sb.pop_front();
         if (e.chk) begin
            check_eq("r_t", int'(r_t), e.rt);
            check_eq("g_t", int'(g_t), e.gt);
            check_eq("b_t", int'(b_t), e.bt);
            check_eq("r_s", int'(r_s), e.rs);
            check_eq("g_s", int'(g_s), e.gs);
            check_eq("b_s", int'(b_s), e.bs);
            check_eq("hsync_t", int'(hs_t), int'(e.hs));
            check_eq("vsync_t", int'(vs_t), int'(e.vs));
            check_eq("hsync_s", int'(hs_s), int'(e.hs));
            check_eq("vsync_s", int'(vs_s), int'(e.vs));
            case (e.kind)
               1: dens[e.idx] = int'(b_s);
               2: rot[e.idx]  = int'(b_t);
               3: begin check_eq("sat_r", int'(r_t), 7); check_eq("sat_g", int'(g_t), 0); end
               4: check_eq("lat_r", int'(r_t), 7);
               5: begin check_eq("blank_r", int'(r_t), 0); check_eq("blank_b", int'(b_s), 0); end
               default: ;
            endcase
         end
      end
   endtask

   initial begin
      int ones;
      rst = 1'b1;
      hpos = 10'd0; vpos = 10'd0; vis = 1'b0; hs = 1'b1; vs = 1'b1;
      r = 8'd0; g = 8'd0; b = 8'd0;
      model_reset();
      #1;
      check_eq("rst_r", int'(r_t), 0);
      check_eq("rst_hsync", int'(hs_t), 1);
      check_eq("rst_vsync", int'(vs_t), 1);
      check_eq("rst_frame", int'(fr_t), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;                      // vsync already high at release: must not count

      step(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);

      // temporal rotation: pixel (0,0), b=16, then a vsync pulse, five frames
      for (int f = 0; f < 5; f++) begin
         step(0, 0, 1, 1, 0, 0, 0, 16, 1, 2, f);
         rotfr[f] = int'(fr_t);
         if (f < 4) begin
            step(5, 5, 0, 1, 1, 0, 0, 0, 1, 0, 0);
            step(5, 5, 0, 1, 0, 0, 0, 0, 1, 0, 0);
         end
      end

      // dither density on the static instance
      for (int v = 0; v < 4; v++)
         for (int h = 0; h < 4; h++)
            step(h, v, 1, 1, 0, 0, 0, 16, 1, 1, v * 4 + h);

      // saturation/extremes
      for (int v = 0; v < 4; v++)
         for (int h = 0; h < 4; h++)
            step(h + 8, v + 4, 1, 1, 0, 255, 0, 128, 1, 3, 0);

      // sync latency/alignment with full-scale red
      for (int i = 0; i < 10; i++)
         step(i, 7, 1, (i % 3) != 1, (i % 4) == 2, 255, 40, 200, 1, 4, 0);

      // blanking
      for (int i = 0; i < 4; i++)
         step(i, 9, 0, i[0], 0, 255, 255, 255, 1, 5, 0);

      // mixed random pixels
      for (int i = 0; i < 40; i++)
         step($urandom_range(639, 0), $urandom_range(479, 0), 1'($urandom_range(1, 0)),
              1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
              $urandom_range(255, 0), $urandom_range(255, 0), $urandom_range(255, 0), 1, 0, 0);

      // asynchronous reset mid-frame with data in flight and a non-zero frame phase
      step(1, 1, 0, 1, 1, 0, 0, 0, 1, 0, 0);
      step(1, 1, 1, 0, 0, 255, 255, 255, 0, 0, 0);
      step(2, 1, 1, 0, 0, 255, 255, 255, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_r", int'(r_t), 0);
      check_eq("arst_g", int'(g_s), 0);
      check_eq("arst_hsync", int'(hs_t), 1);
      check_eq("arst_vsync", int'(vs_t), 1);
      check_eq("arst_frame", int'(fr_t), 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 0, 1, 0, 0, 255, 255, 255, 1, 4, 0);
      check_eq("post_rst_r", int'(r_t), 0);
      check_eq("post_rst_hsync", int'(hs_t), 1);
      step(1, 0, 1, 0, 0, 255, 255, 255, 1, 4, 0);
      step(2, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0);

      // flush
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

      ones = 0;
      for (int i = 0; i < 16; i++) ones += dens[i];
      check_eq("dens_count", ones, 8);
      check_eq("dens_00", dens[0], 0);
      check_eq("dens_10", dens[1], 1);
      for (int f = 0; f < 5; f++) begin
         check_eq($sformatf("rot_b%0d", f), rot[f], rot_exp[f]);
         check_eq($sformatf("rot_frame%0d", f), rotfr[f], rotfr_exp[f]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
